// File: rtl/ssp_rx_fifo_param_if.sv
// ssp_rx_fifo_param_if -- signal bundle between the SSP receive FIFO and its
// neighbours: the receive shift logic (RxDATA/RECV), the APB read path
// (PSEL/PWRITE/PRDATA) and the status/interrupt outputs.
//
// Handshake: RECV offers RxDATA for one cycle; the word is taken at the rising
// edge only while VALID (= not full) is high. A RECV while VALID is low is an
// overrun and the word is dropped. A read is PSEL && !PWRITE while RXEMPTY is
// low; PRDATA carries the popped word from the following cycle onward.
//
// Modports:
//   master -- the side that drives RECV/APB/control and observes status.
//   slave  -- the FIFO itself.
interface ssp_rx_fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int AW         = 2
);
  logic                  PSEL;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] RxDATA;
  logic                  RECV;
  logic [AW:0]           RXTHRESH;
  logic                  OVRCLR;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  VALID;
  logic                  RXEMPTY;
  logic [AW:0]           RXLEVEL;
  logic                  SSPRXINTR;
  logic                  RXOVR;

  modport master (
    output PSEL, PWRITE, RxDATA, RECV, RXTHRESH, OVRCLR,
    input  PRDATA, VALID, RXEMPTY, RXLEVEL, SSPRXINTR, RXOVR
  );

  modport slave (
    input  PSEL, PWRITE, RxDATA, RECV, RXTHRESH, OVRCLR,
    output PRDATA, VALID, RXEMPTY, RXLEVEL, SSPRXINTR, RXOVR
  );
endinterface

// File: rtl/ssp_rx_fifo_param.sv
// ssp_rx_fifo_param -- parametrised SSP receive FIFO. Buffers words from the
// receive shift logic and returns them on APB reads, with an occupancy count,
// a programmable interrupt threshold and a sticky overrun flag.
//
// Ports:
//   PCLK     -- single clock, all state changes on the rising edge.
//   CLEAR_B  -- synchronous active-low reset (pointers, count, RXOVR, PRDATA).
//   bus      -- ssp_rx_fifo_param_if.slave:
//                 in : PSEL, PWRITE, RxDATA, RECV, RXTHRESH, OVRCLR
//                 out: PRDATA (registered), VALID, RXEMPTY, RXLEVEL,
//                      SSPRXINTR, RXOVR
//
// The interface instance must be built with the same DATA_WIDTH and AW.
module ssp_rx_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AW         = 2
) (
  input  logic                PCLK,
  input  logic                CLEAR_B,
  ssp_rx_fifo_param_if.slave  bus
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wp;
  logic [AW-1:0]         rp;
  logic [AW:0]           count;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  rxovr_q;

  logic full;
  logic empty;
  logic wre;
  logic rde;
  logic ovr;

  // All qualifiers look at the pre-edge count, so a full FIFO rejects a
  // write even when a read frees a slot in the same cycle, and an empty
  // FIFO ignores a read even when a write arrives in the same cycle.
  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);
  assign wre   = bus.RECV && !full;
  assign ovr   = bus.RECV && full;
  assign rde   = bus.PSEL && !bus.PWRITE && !empty;

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge PCLK) begin
    if (CLEAR_B && wre) begin
      mem[wp] <= bus.RxDATA;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      prdata_q <= '0;
      rxovr_q  <= 1'b0;
    end else begin
      if (wre) begin
        wp <= wp + 1'b1;
      end
      if (rde) begin
        prdata_q <= mem[rp];
        rp       <= rp + 1'b1;
      end
      case ({wre, rde})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Set has priority over clear when both happen in one cycle.
      if (ovr) begin
        rxovr_q <= 1'b1;
      end else if (bus.OVRCLR) begin
        rxovr_q <= 1'b0;
      end
    end
  end

  assign bus.PRDATA    = prdata_q;
  assign bus.VALID     = !full;
  assign bus.RXEMPTY   = empty;
  assign bus.RXLEVEL   = count;
  assign bus.SSPRXINTR = (bus.RXTHRESH != '0) && (count >= bus.RXTHRESH);
  assign bus.RXOVR     = rxovr_q;

endmodule

// File: tb/tb_ssp_rx_fifo_param.sv
// tb_ssp_rx_fifo_param -- bench for ssp_rx_fifo_param. Two instances: the
// default 8x4 FIFO and a 16x8 FIFO. A queue-based reference model tracks
// each instance; every clock step compares all outputs against it, and the
// directed steps add literal expectations from the test plan.
module tb_ssp_rx_fifo_param;

  // ---------------- clock / reset ----------------
  logic PCLK    = 1'b0;
  logic CLEAR_B = 1'b0;
  always #5 PCLK = ~PCLK;

  ssp_rx_fifo_param_if #(.DATA_WIDTH(8),  .AW(2)) b0 ();
  ssp_rx_fifo_param_if #(.DATA_WIDTH(16), .AW(3)) b1 ();

  ssp_rx_fifo_param #(.DATA_WIDTH(8), .DEPTH(4), .AW(2)) u0 (
    .PCLK    (PCLK),
    .CLEAR_B (CLEAR_B),
    .bus     (b0.slave)
  );

  ssp_rx_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .AW(3)) u1 (
    .PCLK    (PCLK),
    .CLEAR_B (CLEAR_B),
    .bus     (b1.slave)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic        ovr0 = 1'b0;
  logic        ovr1 = 1'b0;
  logic [15:0] prd0 = '0;
  logic [15:0] prd1 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // FIFO behaviour as a queue: pop oldest on a read of a non-empty FIFO,
  // append on a receive into a non-full FIFO, both judged on the pre-edge size.
  task automatic model(ref logic [15:0] q[$], inout logic ovr, inout logic [15:0] prd,
                       input int depth, input logic clr, input logic recv,
                       input logic psel, input logic pwrite, input logic ovrclr,
                       input logic [15:0] d);
    bit was_full  = (q.size() == depth);
    bit was_empty = (q.size() == 0);
    if (!clr) begin
      q.delete();
      ovr = 1'b0;
      prd = '0;
    end else begin
      if (psel && !pwrite && !was_empty) prd = q.pop_front();
      if (recv && !was_full) q.push_back(d);
      if (recv && was_full) ovr = 1'b1;
      else if (ovrclr)      ovr = 1'b0;
    end
  endtask

  task automatic check_all();
    int s0 = exp_q0.size();
    int s1 = exp_q1.size();
    chk("u0_level",  32'(b0.RXLEVEL),   s0);
    chk("u0_empty",  32'(b0.RXEMPTY),   32'(s0 == 0));
    chk("u0_valid",  32'(b0.VALID),     32'(s0 < 4));
    chk("u0_intr",   32'(b0.SSPRXINTR), 32'((b0.RXTHRESH != 0) && (s0 >= int'(b0.RXTHRESH))));
    chk("u0_ovr",    32'(b0.RXOVR),     32'(ovr0));
    chk("u0_prdata", 32'(b0.PRDATA),    32'(prd0));
    chk("u1_level",  32'(b1.RXLEVEL),   s1);
    chk("u1_empty",  32'(b1.RXEMPTY),   32'(s1 == 0));
    chk("u1_valid",  32'(b1.VALID),     32'(s1 < 8));
    chk("u1_intr",   32'(b1.SSPRXINTR), 32'((b1.RXTHRESH != 0) && (s1 >= int'(b1.RXTHRESH))));
    chk("u1_ovr",    32'(b1.RXOVR),     32'(ovr1));
    chk("u1_prdata", 32'(b1.PRDATA),    32'(prd1));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: snapshot inputs, take the edge, advance the model, compare.
  task automatic tick();
    logic        c  = CLEAR_B;
    logic        r0 = b0.RECV;
    logic        s0 = b0.PSEL;
    logic        w0 = b0.PWRITE;
    logic        o0 = b0.OVRCLR;
    logic [15:0] d0 = 16'(b0.RxDATA);
    logic        r1 = b1.RECV;
    logic        s1 = b1.PSEL;
    logic        w1 = b1.PWRITE;
    logic        o1 = b1.OVRCLR;
    logic [15:0] d1 = b1.RxDATA;
    @(posedge PCLK);
    #1;
    model(exp_q0, ovr0, prd0, 4, c, r0, s0, w0, o0, d0);
    model(exp_q1, ovr1, prd1, 8, c, r1, s1, w1, o1, d1);
    check_all();
  endtask

  task automatic idle();
    b0.RECV = 1'b0; b0.PSEL = 1'b0; b0.PWRITE = 1'b0; b0.OVRCLR = 1'b0;
    b1.RECV = 1'b0; b1.PSEL = 1'b0; b1.PWRITE = 1'b0; b1.OVRCLR = 1'b0;
  endtask

  task automatic push0(input logic [7:0] d);
    b0.RECV = 1'b1; b0.RxDATA = d; tick(); b0.RECV = 1'b0;
  endtask

  task automatic pop0(input logic [7:0] exp, input string tag);
    b0.PSEL = 1'b1; b0.PWRITE = 1'b0; tick(); b0.PSEL = 1'b0;
    chk(tag, 32'(b0.PRDATA), 32'(exp));
  endtask

  task automatic push1(input logic [15:0] d);
    b1.RECV = 1'b1; b1.RxDATA = d; tick(); b1.RECV = 1'b0;
  endtask

  task automatic pop1(input logic [15:0] exp);
    b1.PSEL = 1'b1; b1.PWRITE = 1'b0; tick(); b1.PSEL = 1'b0;
    chk("u1_drain", 32'(b1.PRDATA), 32'(exp));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    idle();
    b0.RxDATA = '0; b0.RXTHRESH = '0;
    b1.RxDATA = '0; b1.RXTHRESH = '0;

    // Reset held two cycles with RECV asserted.
    CLEAR_B = 1'b0; b0.RECV = 1'b1; b1.RECV = 1'b1;
    tick(); tick();
    CLEAR_B = 1'b1; idle();
    chk("rst_level", 32'(b0.RXLEVEL), 0);
    chk("rst_empty", 32'(b0.RXEMPTY), 1);
    chk("rst_valid", 32'(b0.VALID),   1);
    chk("rst_prdata", 32'(b0.PRDATA), 0);
    chk("rst_ovr",   32'(b0.RXOVR),   0);

    // Fill/drain, twice to wrap the pointers.
    for (int pass = 0; pass < 2; pass++) begin
      logic [7:0] base = (pass == 0) ? 8'hA0 : 8'hB0;
      for (int i = 1; i <= 4; i++) push0(base + 8'(i));
      chk("fill_valid", 32'(b0.VALID),   0);
      chk("fill_level", 32'(b0.RXLEVEL), 4);
      for (int i = 1; i <= 4; i++) pop0(base + 8'(i), "drain_data");
      chk("drain_empty", 32'(b0.RXEMPTY), 1);
    end

    // Overrun: the fifth word is dropped.
    for (int i = 1; i <= 4; i++) push0(8'h10 + 8'(i));
    push0(8'h55);
    chk("ovr_flag",  32'(b0.RXOVR),   1);
    chk("ovr_level", 32'(b0.RXLEVEL), 4);
    for (int i = 1; i <= 4; i++) pop0(8'h10 + 8'(i), "ovr_data");
    b0.OVRCLR = 1'b1; tick(); b0.OVRCLR = 1'b0;
    chk("ovr_clear", 32'(b0.RXOVR), 0);
    for (int i = 1; i <= 4; i++) push0(8'h20 + 8'(i));
    b0.OVRCLR = 1'b1; b0.RECV = 1'b1; b0.RxDATA = 8'h66; tick(); idle();
    chk("ovr_set_wins", 32'(b0.RXOVR), 1);
    for (int i = 1; i <= 4; i++) pop0(8'h20 + 8'(i), "ovr2_data");
    b0.OVRCLR = 1'b1; tick(); b0.OVRCLR = 1'b0;

    // Simultaneous read and write at level 2.
    push0(8'hC1); push0(8'hC2);
    b0.RECV = 1'b1; b0.RxDATA = 8'hC3; b0.PSEL = 1'b1; tick(); idle();
    chk("rw_level", 32'(b0.RXLEVEL), 2);
    chk("rw_data",  32'(b0.PRDATA),  32'h0C1);
    pop0(8'hC2, "rw_drain"); pop0(8'hC3, "rw_drain");
    // Empty + write + read: read ignored, PRDATA holds.
    b0.RECV = 1'b1; b0.RxDATA = 8'hE1; b0.PSEL = 1'b1; tick(); idle();
    chk("empty_rw_level", 32'(b0.RXLEVEL), 1);
    chk("empty_rw_hold",  32'(b0.PRDATA),  32'h0C3);
    push0(8'hE2); push0(8'hE3); push0(8'hE4);
    // Full + write + read: read proceeds, write is an overrun.
    b0.RECV = 1'b1; b0.RxDATA = 8'hE5; b0.PSEL = 1'b1; tick(); idle();
    chk("full_rw_level", 32'(b0.RXLEVEL), 3);
    chk("full_rw_ovr",   32'(b0.RXOVR),   1);
    chk("full_rw_data",  32'(b0.PRDATA),  32'h0E1);
    pop0(8'hE2, "full_rw_drain"); pop0(8'hE3, "full_rw_drain"); pop0(8'hE4, "full_rw_drain");
    b0.OVRCLR = 1'b1; tick(); b0.OVRCLR = 1'b0;

    // Threshold.
    b0.RXTHRESH = 3'd3;
    push0(8'h31); push0(8'h32);
    chk("thr_below", 32'(b0.SSPRXINTR), 0);
    push0(8'h33);
    chk("thr_at", 32'(b0.SSPRXINTR), 1);
    pop0(8'h31, "thr_data");
    chk("thr_after_read", 32'(b0.SSPRXINTR), 0);
    push0(8'h34); push0(8'h35);
    chk("thr_full", 32'(b0.SSPRXINTR), 1);
    b0.RXTHRESH = 3'd0; #1;
    chk("thr_disable", 32'(b0.SSPRXINTR), 0);
    pop0(8'h32, "thr_drain"); pop0(8'h33, "thr_drain");
    pop0(8'h34, "thr_drain"); pop0(8'h35, "thr_drain");

    // Randomised traffic on the 4-deep instance, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      b0.RECV     = ($urandom_range(0, 1) == 1);
      b0.RxDATA   = 8'($urandom_range(0, 255));
      b0.PSEL     = ($urandom_range(0, 2) != 0);
      b0.PWRITE   = ($urandom_range(0, 3) == 0);
      b0.OVRCLR   = ($urandom_range(0, 7) == 0);
      b0.RXTHRESH = 3'($urandom_range(0, 4));
      CLEAR_B     = ($urandom_range(0, 49) != 0);
      tick();
    end
    CLEAR_B = 1'b1; idle(); b0.RXTHRESH = '0;
    CLEAR_B = 1'b0; tick(); CLEAR_B = 1'b1;

    // Wider/deeper instance: fill, overrun, partial drain, reset mid-drain.
    b1.RXTHRESH = 4'd8;
    for (int i = 1; i <= 8; i++) push1(16'(i));
    push1(16'h0009);
    chk("u1_full_valid", 32'(b1.VALID),     0);
    chk("u1_full_ovr",   32'(b1.RXOVR),     1);
    chk("u1_full_level", 32'(b1.RXLEVEL),   8);
    chk("u1_full_intr",  32'(b1.SSPRXINTR), 1);
    for (int i = 1; i <= 4; i++) pop1(16'(i));
    CLEAR_B = 1'b0; tick(); CLEAR_B = 1'b1;
    chk("u1_mid_reset_level", 32'(b1.RXLEVEL), 0);
    chk("u1_mid_reset_ovr",   32'(b1.RXOVR),   0);
    push1(16'hBEEF);
    pop1(16'hBEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ssp_rx_fifo_param.md
# ssp_rx_fifo_param

Parametrised receive FIFO for the SSP block: it buffers words delivered by the receive logic and returns them on APB reads. It sits between the SSP receive shift logic (RxDATA/RECV) and the APB slave read path (PSEL/PWRITE/PRDATA). It generalises the fixed 4×8 receive FIFO with:
- configurable width and depth;
- an occupancy count;
- a programmable interrupt threshold;
- a sticky overrun flag;
- defined simultaneous read/write behaviour.

## Interface

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 4, number of entries; power of two, ≥ 2.
- AW, 2, pointer width; must equal log2(DEPTH). Count and threshold are AW+1 bits.

Ports:
- PCLK  in  1  single clock; all state changes on rising edge.
- CLEAR_B  in  1  synchronous, active-low reset; clears pointers, count, flags and outputs.
- PSEL  in  1  APB select.
- PWRITE  in  1  APB direction; 1 = write cycle, which is ignored by this FIFO.
- RxDATA  in  DATA_WIDTH  word from receive logic.
- RECV  in  1  receive logic presents a word this cycle.
- RXTHRESH  in  AW+1  interrupt threshold in entries; 0 disables the interrupt.
- OVRCLR  in  1  one-cycle pulse that clears RXOVR.
- PRDATA  out  DATA_WIDTH  registered read data.
- VALID  out  1  FIFO can accept a word (= !full).
- RXEMPTY  out  1  count == 0.
- RXLEVEL  out  AW+1  current occupancy, 0..DEPTH.
- SSPRXINTR  out  1  (RXTHRESH != 0) && (RXLEVEL >= RXTHRESH).
- RXOVR  out  1  sticky overrun flag.

## Operation

- Storage: DEPTH × DATA_WIDTH register array.
- Write pointer wp and read pointer rp are AW bits and wrap naturally from DEPTH-1 to 0.
- count is AW+1 bits; full = (count == DEPTH), empty = (count == 0).
- **Write** (wre = RECV && !full): mem[wp] <= RxDATA; wp <= wp+1.
- **Overrun** (RECV && full): the word is discarded; mem, wp and count are unchanged; RXOVR <= 1.
- **Read** (rde = PSEL && !PWRITE && !empty): PRDATA <= mem[rp]; rp <= rp+1.
- Read attempted while empty: no state change; PRDATA holds its previous value.
- PWRITE = 1 or PSEL = 0: PRDATA holds; no pointer change.
- Count update, evaluated on pre-edge state:
  - wre && !rde: +1
  - rde && !wre: −1
  - both: unchanged
  - neither: unchanged
- Simultaneous events:
  - Full + RECV + rde: the read proceeds, the write is rejected as overrun (full is sampled pre-edge), and count goes to DEPTH−1.
  - Empty + RECV + read: the write proceeds and the read is ignored; count goes to 1.
- RXOVR:
  - set on an overrun;
  - cleared by OVRCLR;
  - if an overrun and OVRCLR occur in the same cycle, set wins;
  - cleared by reset.
- No state machine beyond the pointers and count; the FIFO is a pure circular buffer.

## Timing

- Reset (CLEAR_B = 0 at a rising edge):
  - wp, rp, count = 0; RXOVR = 0; PRDATA = 0.
  - Outputs one cycle after reset: VALID = 1, RXEMPTY = 1, RXLEVEL = 0, SSPRXINTR = 0.
  - Reset overrides any RECV or read in the same cycle.
  - A mid-operation reset discards all contents; memory contents need not be cleared.
- Write latency: a word accepted at edge N is visible in RXLEVEL after edge N and is readable from cycle N+1 onward.
- Read latency: PRDATA is valid after the edge that samples rde (1 cycle); the consumer samples it in the following APB access phase.
- VALID, RXEMPTY, RXLEVEL and SSPRXINTR are combinational from registered count/RXTHRESH; there are no combinational paths from RECV or PSEL to any output.
- RXTHRESH changes take effect on SSPRXINTR in the same cycle.

## Test plan

- **Reset:** drive CLEAR_B = 0 for 2 cycles with RECV = 1 → RXLEVEL = 0, RXEMPTY = 1, VALID = 1, PRDATA = 0, RXOVR = 0.
- **Fill/drain with wrap (DEPTH = 4):** write 0xA1, 0xA2, 0xA3, 0xA4 → VALID = 0, RXLEVEL = 4. Read 4 times → PRDATA = A1, A2, A3, A4; RXEMPTY = 1. Repeat with 0xB1–0xB4 to exercise pointer wrap → same order returned.
- **Overrun:** fill with 0x11–0x14, then RECV with 0x55 → RXOVR = 1, RXLEVEL = 4. Four reads return 0x11–0x14 (0x55 never appears). OVRCLR pulse → RXOVR = 0. Overrun and OVRCLR in the same cycle → RXOVR = 1.
- **Simultaneous read/write:**
  - At level 2, RECV + read in the same cycle → RXLEVEL stays 2 and the oldest word is returned.
  - Empty + RECV + read → RXLEVEL = 1, PRDATA unchanged.
  - Full + RECV + read → RXLEVEL = 3, RXOVR = 1.
- **Threshold:** RXTHRESH = 3; write 2 words → SSPRXINTR = 0; 3rd word → SSPRXINTR = 1; read 1 → SSPRXINTR = 0. RXTHRESH = 0 while full → SSPRXINTR = 0.
- **Parameter sweep:** DATA_WIDTH = 16, DEPTH = 8, AW = 3. Write 0x0001–0x0008 then 1 more → VALID = 0, RXOVR = 1, RXLEVEL = 8. Reads return 0x0001–0x0008 in order. Reset mid-drain → RXLEVEL = 0 next cycle.
